// File: rtl/m_load_ext_pipe_pkg.sv
// Shared types for the registered load-data extender.
// The size encoding matches the LSU load-size field.
package m_load_ext_pipe_pkg;

  typedef enum logic [1:0] {
    LDX_BYTE  = 2'd0,
    LDX_HALF  = 2'd1,
    LDX_WORD  = 2'd2,
    LDX_DWORD = 2'd3
  } ldx_size_e;

endpackage

// File: rtl/m_load_ext_core.sv
// Combinational lane select, sign/zero extension and alignment fault detection
// for one load beat. No state; the pipe wrapper registers the result.
module m_load_ext_core
  import m_load_ext_pipe_pkg::*;
#(
  parameter int DW     = 32,
  localparam int LANE_W = $clog2(DW/8)
) (
  input  logic [DW-1:0]     rdata,
  input  logic [LANE_W-1:0] addr,
  input  ldx_size_e         size,
  input  logic              is_signed,
  output logic [DW-1:0]     data,
  output logic              fault
);

  localparam logic [DW-1:0] ONES = '1;

  logic [LANE_W-1:0] low_mask;
  logic [LANE_W-1:0] lane;
  logic [DW-1:0]     shifted;
  logic [DW-1:0]     keep_mask;
  logic              msb;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    low_mask  = '0;
    keep_mask = ONES;
    msb       = 1'b0;
    data      = '0;
    fault     = 1'b0;

    case (size)
      LDX_BYTE: begin
        low_mask  = '0;
        keep_mask = ONES >> (DW - 8);
      end
      LDX_HALF: begin
        low_mask  = LANE_W'(1);
        keep_mask = ONES >> (DW - 16);
      end
      LDX_WORD: begin
        low_mask  = LANE_W'(3);
        keep_mask = ONES >> (DW - 32);
      end
      default: begin
        low_mask  = LANE_W'(7);
        keep_mask = ONES;
      end
    endcase

    // Align the addressed field down to bit 0; the lane is the address rounded
    // down to the access size, so a misaligned address still indexes a real lane.
    lane    = addr & ~low_mask;
    shifted = rdata >> {lane, 3'b000};

    case (size)
      LDX_BYTE: msb = shifted[7];
      LDX_HALF: msb = shifted[15];
      LDX_WORD: msb = shifted[31];
      default:  msb = shifted[DW-1];
    endcase

    fault = ((addr & low_mask) != '0) || (size == LDX_DWORD && DW == 32);

    if (!fault) begin
      data = (shifted & keep_mask) | ((is_signed && msb) ? ~keep_mask : '0);
    end
  end

endmodule

// File: rtl/m_load_ext_pipe.sv
// M->W load-data extender: one output register with valid/ready handshake,
// flush, and a saturating count of faulted beats.
module m_load_ext_pipe
  import m_load_ext_pipe_pkg::*;
#(
  parameter int DW        = 32,
  parameter int ERR_CNT_W = 8,
  localparam int LANE_W   = $clog2(DW/8)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DW-1:0]        i_rdata,
  input  logic [LANE_W-1:0]    i_addr,
  input  logic [1:0]           i_size,
  input  logic                 i_signed,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DW-1:0]        o_data,
  output logic                 o_fault,
  output logic [ERR_CNT_W-1:0] o_fault_cnt
);

  logic [DW-1:0] core_data;
  logic          core_fault;
  logic          accept;

  m_load_ext_core #(.DW(DW)) u_core (
    .rdata     (i_rdata),
    .addr      (i_addr),
    .size      (ldx_size_e'(i_size)),
    .is_signed (i_signed),
    .data      (core_data),
    .fault     (core_fault)
  );

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready && !i_flush;

  // NOTE: the data register is reset along with the control bits so a reset
  // mid-transfer leaves nothing of the old beat visible on o_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_fault     <= 1'b0;
      o_fault_cnt <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every register update in this block
      // based on pre-edge values, independent of statement order.
      o_valid <= 1'b1;
      o_data  <= core_data;
      o_fault <= core_fault;
      if (core_fault && o_fault_cnt != '1) begin
        o_fault_cnt <= o_fault_cnt + 1'b1;
      end
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_m_load_ext_pipe.sv
// Self-checking bench for m_load_ext_pipe: directed scenarios plus a
// scoreboard monitor that checks every beat leaving the 32-bit instance.
module tb_m_load_ext_pipe;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic        i_ready;
  logic        i_flush;
  logic [31:0] i_rdata;
  logic [1:0]  i_addr;
  logic [1:0]  i_size;
  logic        i_signed;

  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_fault;
  logic [7:0]  o_fault_cnt;

  logic        sat_o_ready, sat_o_valid, sat_o_fault;
  logic [31:0] sat_o_data;
  logic [1:0]  sat_o_fault_cnt;

  logic [63:0] i_rdata64;
  logic [2:0]  i_addr64;
  logic        w_o_ready, w_o_valid, w_o_fault;
  logic [63:0] w_o_data;
  logic [7:0]  w_o_fault_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt     = 0;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];

  m_load_ext_pipe #(.DW(32), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_rdata(i_rdata), .i_addr(i_addr), .i_size(i_size), .i_signed(i_signed),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_fault(o_fault), .o_fault_cnt(o_fault_cnt)
  );

  m_load_ext_pipe #(.DW(32), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(sat_o_ready),
    .i_rdata(i_rdata), .i_addr(i_addr), .i_size(i_size), .i_signed(i_signed),
    .i_flush(i_flush), .o_valid(sat_o_valid), .i_ready(i_ready), .o_data(sat_o_data),
    .o_fault(sat_o_fault), .o_fault_cnt(sat_o_fault_cnt)
  );

  m_load_ext_pipe #(.DW(64), .ERR_CNT_W(8)) dut64 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(w_o_ready),
    .i_rdata(i_rdata64), .i_addr(i_addr64), .i_size(i_size), .i_signed(i_signed),
    .i_flush(i_flush), .o_valid(w_o_valid), .i_ready(i_ready), .o_data(w_o_data),
    .o_fault(w_o_fault), .o_fault_cnt(w_o_fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of the DW=32 extender, written from the lane table.
  function automatic exp_t model32(input logic [31:0] rd, input logic [1:0] a,
                                   input logic [1:0] sz, input logic sg);
    exp_t e;
    logic [7:0]  b;
    logic [15:0] h;
    e.data  = 32'h0;
    e.fault = 1'b0;
    e.cnt   = 8'h0;
    case (sz)
      2'd0: begin
        case (a)
          2'd0: b = rd[7:0];
          2'd1: b = rd[15:8];
          2'd2: b = rd[23:16];
          default: b = rd[31:24];
        endcase
        e.data = (sg && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
      end
      2'd1: begin
        if (a[0]) e.fault = 1'b1;
        else begin
          h = a[1] ? rd[31:16] : rd[15:0];
          e.data = (sg && h[15]) ? {16'hFFFF, h} : {16'h0, h};
        end
      end
      2'd2: begin
        if (a != 2'd0) e.fault = 1'b1;
        else e.data = rd;
      end
      default: e.fault = 1'b1;
    endcase
    return e;
  endfunction

  // Scoreboard: pop/compare the beat leaving, then push the beat entering.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      vectors++;
      if (o_valid !== (sb.size() != 0)) begin
        miscompares++;
        $display("FAIL occupancy: o_valid=%0b expected=%0b", o_valid, sb.size() != 0);
      end
      if (i_flush) begin
        if (sb.size() != 0) void'(sb.pop_front());
      end else if (o_valid && i_ready && sb.size() != 0) begin
        e = sb.pop_front();
        vectors++;
        if (o_data !== e.data || o_fault !== e.fault || o_fault_cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL sb_beat: got data=%h fault=%0b cnt=%0d expected data=%h fault=%0b cnt=%0d",
                   o_data, o_fault, o_fault_cnt, e.data, e.fault, e.cnt);
        end
      end
      if (i_valid && o_ready && !i_flush) begin
        e = model32(i_rdata, i_addr, i_size, i_signed);
        if (e.fault && exp_cnt < 255) exp_cnt++;
        e.cnt = 8'(exp_cnt);
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [31:0] rd, input logic [1:0] a,
                      input logic [1:0] sz, input logic sg);
    i_rdata  = rd;
    i_addr   = a;
    i_size   = sz;
    i_signed = sg;
    i_valid  = 1'b1;
    @(posedge clk); #1;
    i_valid  = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] data,
                         input logic fault, input logic [7:0] cnt);
    vectors++;
    if (o_valid !== 1'b1 || o_data !== data || o_fault !== fault || o_fault_cnt !== cnt) begin
      miscompares++;
      $display("FAIL %s: got v=%0b data=%h fault=%0b cnt=%0d expected v=1 data=%h fault=%0b cnt=%0d",
               name, o_valid, o_data, o_fault, o_fault_cnt, data, fault, cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (o_valid !== 1'b0 || o_data !== 32'h0 || o_fault !== 1'b0 ||
        o_fault_cnt !== 8'h0 || o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: v=%0b data=%h fault=%0b cnt=%0d ready=%0b expected 0/0/0/0/1",
               o_valid, o_data, o_fault, o_fault_cnt, o_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_extend();
    send(32'h8765_43A1, 2'd1, 2'd0, 1'b1); check32("byte_a1_s", 32'h0000_0043, 1'b0, 8'd0);
    send(32'h8765_43A1, 2'd0, 2'd0, 1'b1); check32("byte_a0_s", 32'hFFFF_FFA1, 1'b0, 8'd0);
    send(32'h8765_43A1, 2'd2, 2'd1, 1'b1); check32("half_a2_s", 32'hFFFF_8765, 1'b0, 8'd0);
    send(32'h8765_43A1, 2'd2, 2'd1, 1'b0); check32("half_a2_u", 32'h0000_8765, 1'b0, 8'd0);
    send(32'h8765_43A1, 2'd3, 2'd0, 1'b0); check32("byte_a3_u", 32'h0000_0087, 1'b0, 8'd0);
    send(32'h8765_43A1, 2'd0, 2'd2, 1'b1); check32("word_a0", 32'h8765_43A1, 1'b0, 8'd0);
  endtask

  task automatic test_fault();
    send(32'h8765_43A1, 2'd1, 2'd1, 1'b1); check32("half_misalign", 32'h0, 1'b1, 8'd1);
    send(32'h8765_43A1, 2'd2, 2'd2, 1'b0); check32("word_misalign", 32'h0, 1'b1, 8'd2);
    send(32'h8765_43A1, 2'd0, 2'd3, 1'b0); check32("dword_dw32", 32'h0, 1'b1, 8'd3);
  endtask

  task automatic test_back_to_back();
    exp_t a, b;
    a = model32(32'h1234_F678, 2'd0, 2'd1, 1'b1);
    b = model32(32'hCAFE_0055, 2'd3, 2'd0, 1'b1);
    @(posedge clk); #1;
    i_ready = 1'b0;
    send(32'h1234_F678, 2'd0, 2'd1, 1'b1);
    i_rdata = 32'hCAFE_0055; i_addr = 2'd3; i_size = 2'd0; i_signed = 1'b1; i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== a.data) begin
        miscompares++;
        $display("FAIL stall_%0d: v=%0b ready=%0b data=%h expected v=1 ready=0 data=%h",
                 k, o_valid, o_ready, o_data, a.data);
      end
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check32("replace_beat", b.data, 1'b0, 8'd3);
    @(posedge clk); #1;
    vectors++;
    if (o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: o_valid=%0b expected 0", o_valid);
    end
  endtask

  task automatic test_flush();
    logic [7:0] cnt_before;
    i_ready = 1'b0;
    send(32'h0000_00FF, 2'd0, 2'd0, 1'b0);
    cnt_before = o_fault_cnt;
    i_rdata = 32'h0; i_addr = 2'd1; i_size = 2'd1; i_signed = 1'b0;
    i_valid = 1'b1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_fault_cnt !== cnt_before) begin
      miscompares++;
      $display("FAIL flush: v=%0b cnt=%0d expected v=0 cnt=%0d", o_valid, o_fault_cnt, cnt_before);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    i_ready = 1'b0;
    send(32'hDEAD_BEEF, 2'd0, 2'd2, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (o_valid !== 1'b0 || o_data !== 32'h0 || o_fault_cnt !== 8'h0) begin
      miscompares++;
      $display("FAIL async_reset: v=%0b data=%h cnt=%0d expected 0/0/0",
               o_valid, o_data, o_fault_cnt);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    logic [1:0] want [5];
    want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 5; k++) begin
      send(32'h0, 2'd1, 2'd1, 1'b0);
      vectors++;
      if (sat_o_fault_cnt !== want[k] || sat_o_fault !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_cnt_%0d: cnt=%0d fault=%0b expected cnt=%0d fault=1",
                 k, sat_o_fault_cnt, sat_o_fault, want[k]);
      end
    end
  endtask

  task automatic test_dw64();
    logic [63:0] want [4];
    logic        wflt [4];
    logic [2:0]  a64  [4];
    logic [1:0]  sz   [4];
    logic        sg   [4];
    a64  = '{3'd0, 3'd4, 3'd6, 3'd4};
    sz   = '{2'd3, 2'd2, 2'd1, 2'd3};
    sg   = '{1'b1, 1'b1, 1'b0, 1'b0};
    want = '{64'h8123_4567_89AB_CDEF, 64'hFFFF_FFFF_8123_4567, 64'h0000_0000_0000_8123, 64'h0};
    wflt = '{1'b0, 1'b0, 1'b0, 1'b1};
    i_rdata64 = 64'h8123_4567_89AB_CDEF;
    for (int k = 0; k < 4; k++) begin
      i_addr64 = a64[k];
      send(32'h89AB_CDEF, 2'd0, sz[k], sg[k]);
      vectors++;
      if (w_o_valid !== 1'b1 || w_o_data !== want[k] || w_o_fault !== wflt[k]) begin
        miscompares++;
        $display("FAIL dw64_%0d: v=%0b data=%h fault=%0b expected v=1 data=%h fault=%0b",
                 k, w_o_valid, w_o_data, w_o_fault, want[k], wflt[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      i_valid  = 1'($urandom_range(0, 1));
      i_ready  = ($urandom_range(0, 3) != 0);
      i_flush  = ($urandom_range(0, 7) == 0);
      i_rdata  = $urandom;
      i_addr   = 2'($urandom_range(0, 3));
      i_size   = 2'($urandom_range(0, 3));
      i_signed = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL random_drain: %0d beats never delivered", sb.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    i_flush   = 1'b0;
    i_rdata   = '0;
    i_addr    = '0;
    i_size    = '0;
    i_signed  = 1'b0;
    i_rdata64 = '0;
    i_addr64  = '0;
    test_reset();
    test_extend();
    test_fault();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_saturate();
    test_dw64();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
